// File: rtl/mult_div_pkg.sv
// Shared types and constants for the signed multiply/divide unit.
// Holds the FSM state encoding, op encodings and the two sign helpers.
package mult_div_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        FINISH  = 2'd3
    } state_e;

    // 0x80000000 maps onto itself, which is its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic             neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, shift in the quotient bit.
module div_step
    import mult_div_pkg::*;
(
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    assign shifted = {rem_i, quot_i[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, divisor_i});
    // When the divisor fits, the true difference is below the divisor, so it
    // is exact in WIDTH bits.
    assign diff    = shifted[WIDTH-1:0] - divisor_i;

    assign rem_o   = fits ? diff : shifted[WIDTH-1:0];
    assign quot_o  = {quot_i[WIDTH-2:0], fits};

endmodule

// File: rtl/mult_div.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring on magnitudes).
// 32 iterations per operation; HI/LO are written only when a result completes.
module mult_div
    import mult_div_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output state_e           state_o
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] mcand_q;
    logic             booth_q;
    logic             op_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;

    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   acc_d;
    logic [WIDTH-1:0] quo_d;
    logic             booth_d;
    logic [WIDTH-1:0] div_rem_d;
    logic [WIDTH-1:0] div_quo_d;

    div_step u_div_step (
        .rem_i     (acc_q[WIDTH-1:0]),
        .quot_i    (quo_q),
        .divisor_i (mcand_q),
        .rem_o     (div_rem_d),
        .quot_o    (div_quo_d)
    );

    // Booth keeps one guard bit in acc so that subtracting -2^31 cannot overflow.
    always_comb begin
        mcand_ext = {mcand_q[WIDTH-1], mcand_q};
        case ({quo_q[0], booth_q})
            2'b01:   booth_sum = acc_q + mcand_ext;
            2'b10:   booth_sum = acc_q - mcand_ext;
            default: booth_sum = acc_q;
        endcase

        if (state_q == DIV_RUN) begin
            acc_d   = {1'b0, div_rem_d};
            quo_d   = div_quo_d;
            booth_d = 1'b0;
        end else begin
            acc_d   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            quo_d   = {booth_sum[0], quo_q[WIDTH-1:1]};
            booth_d = quo_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            mcand_q   <= '0;
            booth_q   <= 1'b0;
            op_q      <= OP_MULT;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op == OP_DIV && b == '0) begin
                            dz_q <= 1'b1;
                        end else begin
                            busy_q    <= 1'b1;
                            cnt_q     <= '0;
                            acc_q     <= '0;
                            booth_q   <= 1'b0;
                            op_q      <= op;
                            neg_quo_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_rem_q <= a[WIDTH-1];
                            if (op == OP_DIV) begin
                                state_q <= DIV_RUN;
                                quo_q   <= magnitude(a);
                                mcand_q <= magnitude(b);
                            end else begin
                                state_q <= MUL_RUN;
                                quo_q   <= b;
                                mcand_q <= a;
                            end
                        end
                    end
                end
                MUL_RUN, DIV_RUN: begin
                    acc_q   <= acc_d;
                    quo_q   <= quo_d;
                    booth_q <= booth_d;
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_q <= FINISH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FINISH: begin
                    if (op_q == OP_DIV) begin
                        hi_q <= apply_sign(acc_q[WIDTH-1:0], neg_rem_q);
                        lo_q <= apply_sign(quo_q, neg_quo_q);
                    end else begin
                        hi_q <= acc_q[WIDTH-1:0];
                        lo_q <= quo_q;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign state_o  = state_q;

endmodule
